// File: rtl/tran_batch_sequencer.sv
// Batch sequencer for the 4x4 x16 transpose unit: fetches each matrix from memory,
// loads it into the translation module, captures the transposed result and writes it back.
module tran_batch_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcBase,
  input  logic [ADDR_W-1:0] dstBase,
  input  logic [CNT_W-1:0]  numMats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              memReq,
  output logic              memWE,
  output logic [ADDR_W-1:0] memAddr,
  output logic [255:0]      memWData,
  input  logic [255:0]      memRData,
  input  logic              memAck,
  output logic              tranEnable,
  output logic              tranRW,
  output logic              tranMatDecide,
  output logic [255:0]      tranDataIn,
  input  logic [255:0]      fromTranBus
);

  localparam int DATA_W = 256;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, TR_LOAD, TR_READ, TR_CAP, WR_REQ, NEXT, DONE
  } state_t;

  state_t              state, stateNxt;
  logic [ADDR_W-1:0]   srcPtr, dstPtr;
  logic [CNT_W-1:0]    remain;
  logic [TMR_W-1:0]    timer;
  logic [DATA_W-1:0]   dataReg;
  logic                errorReg;
  logic                waiting;
  logic                expired;

  assign waiting = (state == RD_REQ) || (state == WR_REQ);
  // An ack landing on the final wait cycle wins over the timeout.
  assign expired = waiting && !memAck && (timer == TMR_W'(TIMEOUT - 1));
  assign error   = errorReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      srcPtr   <= '0;
      dstPtr   <= '0;
      remain   <= '0;
      timer    <= '0;
      errorReg <= 1'b0;
    end else begin
      state <= stateNxt;
      timer <= (waiting && stateNxt == state) ? timer + TMR_W'(1) : '0;
      case (state)
        IDLE: begin
          if (start) begin
            errorReg <= 1'b0;
            srcPtr   <= srcBase;
            dstPtr   <= dstBase;
            remain   <= numMats;
          end
        end
        RD_REQ, WR_REQ: begin
          if (expired) errorReg <= 1'b1;
        end
        NEXT: begin
          srcPtr <= srcPtr + ADDR_W'(1);
          dstPtr <= dstPtr + ADDR_W'(1);
          remain <= remain - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Matrix payload register: no reset, every path writes it before it is driven out.
  always_ff @(posedge clk) begin
    if (state == RD_REQ && memAck) dataReg <= memRData;
    else if (state == TR_CAP)      dataReg <= fromTranBus;
  end

  always_comb begin
    stateNxt      = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    memReq        = 1'b0;
    memWE         = 1'b0;
    memAddr       = '0;
    memWData      = '0;
    tranEnable    = 1'b0;
    tranRW        = 1'b0;
    tranMatDecide = 1'b0;
    tranDataIn    = '0;
    case (state)
      IDLE: begin
        if (start) stateNxt = (numMats == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        memReq  = !memAck;
        memAddr = srcPtr;
        if (memAck)       stateNxt = TR_LOAD;
        else if (expired) stateNxt = DONE;
      end
      TR_LOAD: begin
        tranEnable = 1'b1;
        tranRW     = 1'b1;
        tranDataIn = dataReg;
        stateNxt   = TR_READ;
      end
      TR_READ: begin
        tranEnable = 1'b1;
        stateNxt   = TR_CAP;
      end
      TR_CAP: stateNxt = WR_REQ;
      WR_REQ: begin
        memReq   = !memAck;
        memWE    = 1'b1;
        memAddr  = dstPtr;
        memWData = dataReg;
        if (memAck)       stateNxt = NEXT;
        else if (expired) stateNxt = DONE;
      end
      NEXT: stateNxt = (remain == CNT_W'(1)) ? DONE : RD_REQ;
      DONE: begin
        done     = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tran_batch_sequencer.sv
// Bench for tran_batch_sequencer: behavioural memory with random ack latency,
// a behavioural transpose unit, and expected results derived from the transpose rule.
module tb_tran_batch_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  srcBase = '0, dstBase = '0;
  logic [7:0]   numMats = '0;
  logic         busy, done, error, memReq, memWE;
  logic [15:0]  memAddr;
  logic [255:0] memWData, tranDataIn;
  logic [255:0] memRData = '0, fromTranBus = '0;
  logic         memAck = 1'b0;
  logic         tranEnable, tranRW, tranMatDecide;

  tran_batch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .srcBase(srcBase), .dstBase(dstBase),
    .numMats(numMats), .busy(busy), .done(done), .error(error), .memReq(memReq),
    .memWE(memWE), .memAddr(memAddr), .memWData(memWData), .memRData(memRData),
    .memAck(memAck), .tranEnable(tranEnable), .tranRW(tranRW),
    .tranMatDecide(tranMatDecide), .tranDataIn(tranDataIn), .fromTranBus(fromTranBus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] transpose(input logic [255:0] m);
    logic [255:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[16*(4*c+r) +: 16] = m[16*(4*r+c) +: 16];
    return t;
  endfunction

  function automatic logic [255:0] randMat();
    logic [255:0] m;
    for (int k = 0; k < 8; k++) m[32*k +: 32] = $urandom;
    return m;
  endfunction

  // Behavioural memory: one outstanding transaction, ack after a random latency.
  logic [255:0] mem [bit [15:0]];
  logic [16:0]  txnLog [$];
  int           latMin = 1, latMax = 1;
  int           rdTotal = 0, holdAt = -1;
  bit           pending = 0, held = 0;
  int           countdown = 0;
  logic         curWe;
  logic [15:0]  curAddr;
  logic [255:0] curData;

  always begin
    @(posedge clk); #1;
    if (memAck) begin memAck = 1'b0; pending = 0; end
    #1;
    if (pending) begin
      if (held) begin
        if (!memReq) begin pending = 0; held = 0; end
      end else begin
        countdown--;
        if (countdown <= 0) begin
          memAck = 1'b1;
          if (curWe) mem[curAddr] = curData;
          else       memRData = mem[curAddr];
        end
      end
    end else if (memReq) begin
      curWe = memWE; curAddr = memAddr; curData = memWData;
      txnLog.push_back({memWE, memAddr});
      pending = 1;
      countdown = $urandom_range(latMax, latMin);
      if (!memWE) begin
        rdTotal++;
        if (rdTotal == holdAt) held = 1;
      end
    end
  end

  // Behavioural transpose unit: load on enable&RW, present transpose one cycle after read-out.
  logic [255:0] tranStore = '0;
  logic         teS, rwS;
  logic [255:0] dinS;
  always begin
    @(negedge clk);
    teS = tranEnable; rwS = tranRW; dinS = tranDataIn;
    @(posedge clk); #1;
    if (teS && rwS)  tranStore = dinS;
    if (teS && !rwS) fromTranBus = transpose(tranStore);
  end

  int doneCnt = 0, busyCnt = 0, tranEnCnt = 0, reqCnt = 0, matDecCnt = 0;
  always @(negedge clk) begin
    if (done === 1'b1)          doneCnt++;
    if (busy === 1'b1)          busyCnt++;
    if (tranEnable === 1'b1)    tranEnCnt++;
    if (memReq === 1'b1)        reqCnt++;
    if (tranMatDecide !== 1'b0) matDecCnt++;
  end

  int sDone, sBusy, sTran, sReq, sLog;
  task automatic snap();
    sDone = doneCnt; sBusy = busyCnt; sTran = tranEnCnt; sReq = reqCnt; sLog = txnLog.size();
  endtask

  task automatic pulseStart(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    @(posedge clk); #3;
    srcBase = s; dstBase = d; numMats = n; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(posedge clk); #3; n++; end
    check(tag, done, 1'b1);
    @(posedge clk); #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] m0, m1, m2, seq;
  logic [255:0] sentinel [4];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_memReq", memReq, 0);
    check("rst_tranEnable", tranEnable, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWData", memWData, 0);
    reset = 1'b0;
    @(posedge clk); #3;

    // Single matrix, zero-wait memory
    for (int e = 0; e < 16; e++) seq[16*e +: 16] = 16'(e);
    mem[16'h0010] = seq;
    mem[16'h0020] = '0;
    latMin = 1; latMax = 1;
    snap();
    pulseStart(16'h0010, 16'h0020, 8'd1);
    waitDone("single_done_seen");
    check("single_result", mem[16'h0020], transpose(seq));
    check("single_done_cnt", doneCnt - sDone, 1);
    check("single_busy_cycles", busyCnt - sBusy, 9);
    check("single_tranEn_cycles", tranEnCnt - sTran, 2);
    check("single_req_cycles", reqCnt - sReq, 2);

    // Batch of 3 with random latency
    m0 = randMat(); m1 = randMat(); m2 = randMat();
    mem[16'h0100] = m0; mem[16'h0101] = m1; mem[16'h0102] = m2;
    latMin = 1; latMax = 10;
    snap();
    pulseStart(16'h0100, 16'h0200, 8'd3);
    waitDone("batch3_done_seen");
    check("batch3_dst0", mem[16'h0200], transpose(m0));
    check("batch3_dst1", mem[16'h0201], transpose(m1));
    check("batch3_dst2", mem[16'h0202], transpose(m2));
    check("batch3_done_cnt", doneCnt - sDone, 1);
    check("batch3_tranEn_cycles", tranEnCnt - sTran, 6);
    check("batch3_txn_count", txnLog.size() - sLog, 6);
    for (int k = 0; k < 3; k++) begin
      if (txnLog.size() >= sLog + 2*k + 2) begin
        check("batch3_order_rd", txnLog[sLog + 2*k],     {1'b0, 16'h0100 + 16'(k)});
        check("batch3_order_wr", txnLog[sLog + 2*k + 1], {1'b1, 16'h0200 + 16'(k)});
      end
    end

    // numMats = 0: done on the cycle after start, no memory traffic
    latMin = 1; latMax = 1;
    snap();
    pulseStart(16'h0000, 16'h0000, 8'd0);
    check("zero_done_next_cycle", done, 1);
    @(posedge clk); #3;
    check("zero_done_one_pulse", done, 0);
    repeat (3) @(posedge clk);
    #3;
    check("zero_req_cycles", reqCnt - sReq, 0);
    check("zero_busy_after", busy, 0);

    // Timeout on the second read of a batch of 4
    for (int k = 0; k < 4; k++) begin
      mem[16'h0300 + 16'(k)] = randMat();
      sentinel[k] = randMat();
      mem[16'h0400 + 16'(k)] = sentinel[k];
    end
    holdAt = rdTotal + 2;
    snap();
    pulseStart(16'h0300, 16'h0400, 8'd4);
    waitDone("timeout_done_seen");
    check("timeout_error", error, 1);
    check("timeout_memReq_low", memReq, 0);
    check("timeout_busy_cycles", busyCnt - sBusy, 73);
    check("timeout_req_cycles", reqCnt - sReq, 66);
    check("timeout_done_cnt", doneCnt - sDone, 1);
    check("timeout_first_written", mem[16'h0400], transpose(mem[16'h0300]));
    for (int k = 1; k < 4; k++)
      check("timeout_untouched", mem[16'h0400 + 16'(k)], sentinel[k]);
    repeat (3) @(posedge clk);
    #3;
    check("timeout_error_sticky", error, 1);
    holdAt = -1;
    pulseStart(16'h0301, 16'h0500, 8'd1);
    check("timeout_error_cleared", error, 0);
    waitDone("followup_done_seen");
    check("followup_result", mem[16'h0500], transpose(mem[16'h0301]));

    // Reset during the second matrix's write
    for (int k = 0; k < 3; k++) mem[16'h0600 + 16'(k)] = randMat();
    latMin = 4; latMax = 4;
    pulseStart(16'h0600, 16'h0700, 8'd3);
    begin
      int n;
      n = 0;
      while (!(memReq === 1'b1 && memWE === 1'b1 && memAddr === 16'h0701) && n < 500) begin
        @(posedge clk); #3; n++;
      end
      check("reset_reached_wr2", n < 500, 1);
    end
    reset = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_memReq", memReq, 0);
    check("reset_memWE", memWE, 0);
    check("reset_memAddr", memAddr, 0);
    check("reset_memWData", memWData, 0);
    check("reset_tranEnable", tranEnable, 0);
    check("reset_done", done, 0);
    snap();
    repeat (8) @(posedge clk);
    #3;
    check("reset_late_ack_busy", busyCnt - sBusy, 0);
    check("reset_late_ack_req", reqCnt - sReq, 0);
    check("reset_late_ack_done", doneCnt - sDone, 0);
    latMin = 1; latMax = 1;
    pulseStart(16'h0602, 16'h0800, 8'd1);
    waitDone("reset_fresh_done_seen");
    check("reset_fresh_result", mem[16'h0800], transpose(mem[16'h0602]));

    // Address wrap and a start ignored while busy
    mem[16'hFFFF] = randMat();
    mem[16'h0000] = randMat();
    mem[16'h1234] = randMat();
    snap();
    pulseStart(16'hFFFF, 16'h0900, 8'd2);
    repeat (2) @(posedge clk);
    #3;
    srcBase = 16'h1234; dstBase = 16'h0A00; numMats = 8'd5; start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
    waitDone("wrap_done_seen");
    repeat (4) @(posedge clk);
    #3;
    check("wrap_txn_count", txnLog.size() - sLog, 4);
    if (txnLog.size() >= sLog + 4) begin
      check("wrap_rd0", txnLog[sLog],     {1'b0, 16'hFFFF});
      check("wrap_wr0", txnLog[sLog + 1], {1'b1, 16'h0900});
      check("wrap_rd1", txnLog[sLog + 2], {1'b0, 16'h0000});
      check("wrap_wr1", txnLog[sLog + 3], {1'b1, 16'h0901});
    end
    check("wrap_dst0", mem[16'h0900], transpose(mem[16'hFFFF]));
    check("wrap_dst1", mem[16'h0901], transpose(mem[16'h0000]));
    check("wrap_done_cnt", doneCnt - sDone, 1);
    check("wrap_idle_after", busy, 0);
    check("matDecide_never_set", matDecCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
